// File: rtl/frame_luma_stats.sv
// ---------------------------------------------------------------------------
// frame_luma_stats
//   Per-frame luminance statistics tap sitting after the gamma LUT. Watches the
//   gamma-corrected pixel stream and, at every rising edge of vertical sync,
//   reports pixel count, sum, min, max and floor(sum/count) for the frame that
//   just ended. Feeds auto-exposure; it never touches the video path.
//
// Ports
//   video_clk      pixel clock, all logic on rising edge
//   rst            synchronous active-high reset
//   video_vs       vertical sync, rising edge marks a frame boundary
//   video_de       pixel valid
//   video_data     pixel value, qualified by video_de
//   stat_valid     one-cycle pulse, stat_* outputs just updated
//   stat_pix_cnt   pixels in reported frame
//   stat_sum       sum of pixel values
//   stat_min       minimum pixel value
//   stat_max       maximum pixel value
//   stat_mean      floor(stat_sum / stat_pix_cnt)
//   stat_overflow  pixel counter saturated during reported frame
//   stat_drop      one-cycle pulse, a finished frame was discarded because
//                  the divider was still busy
// ---------------------------------------------------------------------------
module frame_luma_stats #(
    parameter int DATA_W    = 8,
    parameter int PIX_CNT_W = 22,
    parameter int SUM_W     = DATA_W + PIX_CNT_W
) (
    input  logic                 video_clk,
    input  logic                 rst,
    input  logic                 video_vs,
    input  logic                 video_de,
    input  logic [DATA_W-1:0]    video_data,
    output logic                 stat_valid,
    output logic [PIX_CNT_W-1:0] stat_pix_cnt,
    output logic [SUM_W-1:0]     stat_sum,
    output logic [DATA_W-1:0]    stat_min,
    output logic [DATA_W-1:0]    stat_max,
    output logic [DATA_W-1:0]    stat_mean,
    output logic                 stat_overflow,
    output logic                 stat_drop
);

    localparam int ITER_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef struct packed {
        logic [PIX_CNT_W-1:0] cnt;
        logic [SUM_W-1:0]     sum;
        logic [DATA_W-1:0]    min;
        logic [DATA_W-1:0]    max;
        logic                 ovf;
    } frame_t;

    typedef enum logic {WAIT_VS, ACCUM} acc_state_t;
    typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_t;

    logic       vs_d;
    logic       vs_edge;
    acc_state_t acc_state;
    frame_t     frm;
    frame_t     frm_upd;    // running frame with this cycle's pixel folded in
    frame_t     frm_fresh;  // new frame whose first pixel may be this cycle's

    div_state_t          div_state;
    frame_t              div_frm;
    logic [SUM_W-1:0]    div_rem;
    logic [SUM_W-1:0]    div_den;
    logic [DATA_W-1:0]   div_q;
    logic [ITER_W-1:0]   div_iter;

    assign vs_edge = video_vs & ~vs_d;

    always_comb begin
        frm_upd = frm;
        if (video_de) begin
            // Saturated counter freezes cnt and sum together so sum <= max*cnt
            // still holds and the quotient keeps fitting in DATA_W bits.
            if (!(&frm.cnt)) begin
                frm_upd.cnt = frm.cnt + PIX_CNT_W'(1);
                frm_upd.sum = frm.sum + SUM_W'(video_data);
            end else begin
                frm_upd.ovf = 1'b1;
            end
            if (video_data < frm.min) frm_upd.min = video_data;
            if (video_data > frm.max) frm_upd.max = video_data;
        end
    end

    always_comb begin
        frm_fresh.cnt = '0;
        frm_fresh.sum = '0;
        frm_fresh.min = '1;
        frm_fresh.max = '0;
        frm_fresh.ovf = 1'b0;
        if (video_de) begin
            frm_fresh.cnt = PIX_CNT_W'(1);
            frm_fresh.sum = SUM_W'(video_data);
            frm_fresh.min = video_data;
            frm_fresh.max = video_data;
        end
    end

    // Accumulator. A pixel arriving in the vs edge cycle opens the new frame.
    always_ff @(posedge video_clk) begin
        if (rst) begin
            vs_d      <= 1'b0;
            acc_state <= WAIT_VS;
            frm.cnt   <= '0;
            frm.sum   <= '0;
            frm.min   <= '1;
            frm.max   <= '0;
            frm.ovf   <= 1'b0;
        end else begin
            vs_d <= video_vs;
            case (acc_state)
                WAIT_VS: begin
                    // Partial frame since reset is never reported.
                    if (vs_edge) begin
                        acc_state <= ACCUM;
                        frm       <= frm_fresh;
                    end
                end
                ACCUM: frm <= vs_edge ? frm_fresh : frm_upd;
                default: acc_state <= WAIT_VS;
            endcase
        end
    end

    // Divider: restoring divide, one quotient bit per cycle MSB first. The
    // divisor starts pre-shifted by DATA_W-1 and walks right each step.
    always_ff @(posedge video_clk) begin
        if (rst) begin
            div_state     <= IDLE;
            div_frm       <= '0;
            div_rem       <= '0;
            div_den       <= '0;
            div_q         <= '0;
            div_iter      <= '0;
            stat_valid    <= 1'b0;
            stat_pix_cnt  <= '0;
            stat_sum      <= '0;
            stat_min      <= '0;
            stat_max      <= '0;
            stat_mean     <= '0;
            stat_overflow <= 1'b0;
            stat_drop     <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            stat_drop  <= 1'b0;
            case (div_state)
                IDLE: begin
                    if (vs_edge && acc_state == ACCUM) begin
                        div_frm   <= frm;
                        div_rem   <= frm.sum;
                        div_den   <= SUM_W'(frm.cnt) << (DATA_W - 1);
                        div_q     <= '0;
                        div_iter  <= ITER_W'(DATA_W - 1);
                        div_state <= DIV;
                    end
                end
                DIV: begin
                    if (div_rem >= div_den) begin
                        div_rem <= div_rem - div_den;
                        div_q   <= {div_q[DATA_W-2:0], 1'b1};
                    end else begin
                        div_q   <= {div_q[DATA_W-2:0], 1'b0};
                    end
                    div_den  <= div_den >> 1;
                    div_iter <= div_iter - ITER_W'(1);
                    if (div_iter == '0) div_state <= DONE;
                end
                DONE: begin
                    // Empty frame still runs the divide (fixed latency) but
                    // its garbage quotient and all-ones min are masked here.
                    if (div_frm.cnt == '0) begin
                        stat_pix_cnt  <= '0;
                        stat_sum      <= '0;
                        stat_min      <= '0;
                        stat_max      <= '0;
                        stat_mean     <= '0;
                        stat_overflow <= 1'b0;
                    end else begin
                        stat_pix_cnt  <= div_frm.cnt;
                        stat_sum      <= div_frm.sum;
                        stat_min      <= div_frm.min;
                        stat_max      <= div_frm.max;
                        stat_mean     <= div_q;
                        stat_overflow <= div_frm.ovf;
                    end
                    stat_valid <= 1'b1;
                    div_state  <= IDLE;
                end
                default: div_state <= IDLE;
            endcase
            // Busy divider keeps its frame; the one just closed is lost.
            if (vs_edge && acc_state == ACCUM && div_state != IDLE)
                stat_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_luma_stats.sv
// ---------------------------------------------------------------------------
// tb_frame_luma_stats
//   Directed bench for frame_luma_stats. Two instances share stimulus: the
//   default-width one and a 4-bit pixel counter one for saturation checks.
//   Inputs change 1 ns after the rising edge and outputs are read there too.
// ---------------------------------------------------------------------------
module tb_frame_luma_stats;

    localparam int DW  = 8;
    localparam int CW  = 22;
    localparam int SW  = DW + CW;
    localparam int CWS = 4;
    localparam int SWS = DW + CWS;

    logic          video_clk  = 1'b0;
    logic          rst        = 1'b1;
    logic          video_vs   = 1'b0;
    logic          video_de   = 1'b0;
    logic [DW-1:0] video_data = '0;

    logic          b_valid, b_ovf, b_drop;
    logic [CW-1:0] b_cnt;
    logic [SW-1:0] b_sum;
    logic [DW-1:0] b_min, b_max, b_mean;

    logic           s_valid, s_ovf, s_drop;
    logic [CWS-1:0] s_cnt;
    logic [SWS-1:0] s_sum;
    logic [DW-1:0]  s_min, s_max, s_mean;

    int n_chk   = 0;
    int n_err   = 0;
    int n_valid = 0;
    int n_drop  = 0;
    int n, v0, d0;

    frame_luma_stats #(.DATA_W(DW), .PIX_CNT_W(CW)) u_big (
        .video_clk(video_clk), .rst(rst), .video_vs(video_vs),
        .video_de(video_de), .video_data(video_data),
        .stat_valid(b_valid), .stat_pix_cnt(b_cnt), .stat_sum(b_sum),
        .stat_min(b_min), .stat_max(b_max), .stat_mean(b_mean),
        .stat_overflow(b_ovf), .stat_drop(b_drop)
    );

    frame_luma_stats #(.DATA_W(DW), .PIX_CNT_W(CWS)) u_small (
        .video_clk(video_clk), .rst(rst), .video_vs(video_vs),
        .video_de(video_de), .video_data(video_data),
        .stat_valid(s_valid), .stat_pix_cnt(s_cnt), .stat_sum(s_sum),
        .stat_min(s_min), .stat_max(s_max), .stat_mean(s_mean),
        .stat_overflow(s_ovf), .stat_drop(s_drop)
    );

    always #5 video_clk = ~video_clk;

    always @(negedge video_clk) begin
        if (b_valid) n_valid <= n_valid + 1;
        if (b_drop)  n_drop  <= n_drop + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_big(input string tag, input int cnt, input int sum, input int mean,
                           input int mn, input int mx, input int ovf);
        chk({tag, "_cnt"},  64'(b_cnt),  64'(cnt));
        chk({tag, "_sum"},  64'(b_sum),  64'(sum));
        chk({tag, "_mean"}, 64'(b_mean), 64'(mean));
        chk({tag, "_min"},  64'(b_min),  64'(mn));
        chk({tag, "_max"},  64'(b_max),  64'(mx));
        chk({tag, "_ovf"},  64'(b_ovf),  64'(ovf));
    endtask

    task automatic chk_small(input string tag, input int cnt, input int sum, input int mean,
                             input int mn, input int mx, input int ovf);
        chk({tag, "_valid"}, 64'(s_valid), 64'd1);
        chk({tag, "_cnt"},   64'(s_cnt),   64'(cnt));
        chk({tag, "_sum"},   64'(s_sum),   64'(sum));
        chk({tag, "_mean"},  64'(s_mean),  64'(mean));
        chk({tag, "_min"},   64'(s_min),   64'(mn));
        chk({tag, "_max"},   64'(s_max),   64'(mx));
        chk({tag, "_ovf"},   64'(s_ovf),   64'(ovf));
    endtask

    task automatic step();
        @(posedge video_clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic pix(input int d);
        video_de   = 1'b1;
        video_data = DW'(d);
        step();
        video_de   = 1'b0;
    endtask

    // One-cycle vs high; optionally with a pixel in that same cycle.
    task automatic vs_pulse(input bit de, input int d);
        video_vs   = 1'b1;
        video_de   = de;
        video_data = DW'(d);
        step();
        video_vs   = 1'b0;
        video_de   = 1'b0;
    endtask

    // Called in cycle T+1; returns k such that stat_valid is seen in T+k.
    task automatic wait_stat(output int k);
        k = 1;
        while (!b_valid && k < 40) begin
            step();
            k++;
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        idle(3);
        chk("rst_valid", 64'(b_valid), 64'd0);
        chk("rst_drop",  64'(b_drop),  64'd0);
        chk_big("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // partial frame after reset is never reported
        repeat (5) pix(200);
        v0 = n_valid; d0 = n_drop;
        vs_pulse(1'b0, 0);
        idle(20);
        chk("first_valid", 64'(n_valid - v0), 64'd0);
        chk("first_drop",  64'(n_drop - d0),  64'd0);
        chk_big("first", 0, 0, 0, 0, 0, 0);

        // basic frame
        pix(10); pix(20); pix(30); pix(41);
        vs_pulse(1'b0, 0);
        wait_stat(n);
        chk("basic_lat", 64'(n), 64'd10);
        chk_big("basic", 4, 101, 25, 10, 41, 0);
        step();
        chk("basic_pulse", 64'(b_valid), 64'd0);
        chk("basic_hold",  64'(b_mean),  64'd25);

        // empty frame
        vs_pulse(1'b0, 0);
        wait_stat(n);
        chk("empty_lat", 64'(n), 64'd10);
        chk_big("empty", 0, 0, 0, 0, 0, 0);

        // full-scale frame; pixel in edge cycle belongs to next frame
        repeat (300) pix(255);
        vs_pulse(1'b1, 7);
        wait_stat(n);
        chk("white_lat", 64'(n), 64'd10);
        chk_big("white", 300, 76500, 255, 255, 255, 0);
        pix(9); pix(11);
        vs_pulse(1'b0, 0);
        wait_stat(n);
        chk_big("carry", 3, 27, 9, 7, 11, 0);

        // counter saturation on the narrow instance
        repeat (20) pix(100);
        vs_pulse(1'b0, 0);
        wait_stat(n);
        chk_big("nosat", 20, 2000, 100, 100, 100, 0);
        chk_small("sat", 15, 1500, 100, 100, 100, 1);
        pix(5); pix(6); pix(7);
        vs_pulse(1'b0, 0);
        wait_stat(n);
        chk_small("unsat", 3, 18, 6, 5, 7, 0);

        // second edge while divider busy
        idle(2);
        pix(50); pix(60);
        v0 = n_valid; d0 = n_drop;
        vs_pulse(1'b0, 0);                  // edge T, now in T+1
        chk("drop_t1", 64'(b_drop), 64'd0);
        pix(1); pix(1); pix(1); pix(1);     // now in T+5
        chk("drop_t5", 64'(b_drop), 64'd0);
        vs_pulse(1'b0, 0);                  // now in T+6
        chk("drop_t6", 64'(b_drop), 64'd1);
        step();                             // T+7
        chk("drop_t7", 64'(b_drop), 64'd0);
        idle(2);                            // T+9
        chk("drop_valid_t9", 64'(b_valid), 64'd0);
        step();                             // T+10
        chk("drop_valid_t10", 64'(b_valid), 64'd1);
        chk_big("kept", 2, 110, 55, 50, 60, 0);
        idle(15);
        chk("drop_one_valid", 64'(n_valid - v0), 64'd1);
        chk("drop_one_pulse", 64'(n_drop - d0),  64'd1);

        // reset mid-divide aborts the report
        pix(80);
        v0 = n_valid;
        vs_pulse(1'b0, 0);                  // now in T+1
        idle(3);                            // T+4
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(20);
        chk("abort_valid", 64'(n_valid - v0), 64'd0);
        chk_big("abort", 0, 0, 0, 0, 0, 0);
        pix(90);
        vs_pulse(1'b0, 0);
        idle(15);
        chk("abort_rearm", 64'(n_valid - v0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/frame_luma_stats.md
Name: frame_luma_stats

Overview:
Per-frame luminance statistics tap placed directly downstream of the gamma lookup stage. It consumes the gamma-corrected 8-bit pixel stream and qualifying DE. At each frame boundary it reports pixel count, sum, min, max and truncated mean. It feeds the auto-exposure / brightness control loop and does not modify the video path.

Parameters:
DATA_W, 8, pixel width; mean, min and max use this width.
PIX_CNT_W, 22, pixel counter width; holds 1920x1080 = 2073600.
SUM_W, DATA_W+PIX_CNT_W (30), accumulator width.

Ports:
video_clk  input  1  pixel clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
video_vs  input  1  vertical sync, active high; rising edge = frame boundary.
video_de  input  1  pixel valid (gamma_de).
video_data  input  DATA_W  pixel value (gamma_data), sampled on the same edge as video_de.
stat_valid  output  1  one-cycle pulse; all stat_* outputs updated.
stat_pix_cnt  output  PIX_CNT_W  pixels in the reported frame.
stat_sum  output  SUM_W  sum of pixel values.
stat_min  output  DATA_W  minimum pixel value.
stat_max  output  DATA_W  maximum pixel value.
stat_mean  output  DATA_W  floor(stat_sum / stat_pix_cnt).
stat_overflow  output  1  pixel counter saturated in the reported frame.
stat_drop  output  1  one-cycle pulse; a frame result was discarded.

Behaviour:
- Reset: all outputs 0; accumulators cleared; accumulate FSM in WAIT_VS; divider FSM in IDLE.
- Edge detect: vs_d holds video_vs registered. An edge occurs in cycle T when video_vs=1 and vs_d=0. A vs held high produces no further edges.
- Accumulate FSM:
  - WAIT_VS: pixels ignored. On the first edge, go to ACCUM. The partial frame after reset is never reported.
  - ACCUM: each cycle with video_de=1 does cnt+=1, sum+=data, min=min(min,data), max=max(max,data).
  - Frame state initial values: cnt=0, sum=0, min=all-ones, max=0.
  - On an edge in cycle T, at the end of T: snapshot {cnt, sum, min, max, ovf} is taken and the frame state is reinitialised. A pixel with de=1 in cycle T belongs to the NEW frame.
- Saturation: when cnt is all-ones, further pixels do not increment cnt or sum but do update min and max; ovf is set for that frame.
- Divider FSM:
  - IDLE: on an edge, load the snapshot and go to DIV (first DIV cycle T+1).
  - DIV: 8-iteration restoring divide of sum by cnt, one quotient bit per cycle, cycles T+1..T+8. The quotient always fits in DATA_W because sum <= 255*cnt.
  - DONE: cycle T+9; output registers are loaded at the end of T+9. stat_valid=1 in cycle T+10 only, then back to IDLE.
  - stat_* outputs hold their values until the next stat_valid.
- Empty frame (cnt=0): no divide, same latency. Report pix_cnt=0, sum=0, mean=0, min=0, max=0, overflow=0.
- Edge while the divider is not IDLE: the divider continues the in-flight frame undisturbed. The just-ended frame is discarded: stat_drop=1 in cycle T+1. The frame state is still reinitialised.
- Reset mid-operation: divider aborts and no stat_valid is produced; return to WAIT_VS.
- Pixels are counted whenever de=1 in ACCUM, independent of video_vs level.

Test Plan:
- Reset, 5 pixels of 200 with de=1, then vs edge, then 20 idle cycles -> no stat_valid, stat_drop=0, outputs remain 0.
- Edge; pixels 10,20,30,41; edge at cycle T -> stat_valid in T+10 with cnt=4, sum=101, mean=25, min=10, max=41, overflow=0.
- Two edges with no de in between -> stat_valid at T+10 with all stat fields 0.
- Full 1920x1080 frame, all 255 -> cnt=2073600, sum=528768000, mean=255, min=max=255. Also: pixel with de=1 in the edge cycle is counted in the next frame.
- PIX_CNT_W=4, 20 pixels of 100 -> cnt=15, sum=1500, mean=100, overflow=1. Then a frame of 3 pixels -> overflow=0.
- Edge at T, second edge at T+5 -> stat_drop pulse at T+6; single stat_valid at T+10 for the first frame. Separately, assert rst at T+4 -> no stat_valid.
